ifetch_queue: RTL and testbench

Instruction prefetch queue sitting between the instruction memory port and the IF/ID pipeline register. It replaces the direct combinational PC→imem→Instr_F path with a request/response memory interface that tolerates variable latency. It buffers up to DEPTH fetched instructions with their PCs and hands them to decode under a valid/ready handshake. It also discards in-flight fetches after a taken branch or jump redirect.

---
 rtl/ifetch_queue_pkg.sv | 22 ++
 rtl/ifetch_queue_sync_fifo.sv | 64 ++++++
 rtl/ifetch_queue.sv | 139 +++++++++++++
 tb/tb_ifetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only together with a pop.
module ifetch_queue_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign rdata_o  = mem_q[rptr_q];
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_i);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_eff) wptr_d = wptr_q + AW'(1);
      if (pop_eff)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue with credit-based fetch issue and redirect discard.
// Define IFQ_BYPASS_EN to forward a live response straight to decode when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pcplus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  ifq_state_e    state_q, state_d;

  logic          req_fire, rsp_live, byp, q_push, q_pop;
  logic          q_full, q_empty, pend_full, pend_empty;
  logic [CW-1:0] q_count, pend_count;
  logic [CW:0]   credit_used;
  logic [31:0]   rsp_pc;
  ifq_entry_t    q_head, q_wdata;

  // Discarded responses never pop the pending-address queue: it is flushed on redirect.
  assign credit_used   = {1'b0, q_count} + {1'b0, inflight_q} - {1'b0, discard_q};
  assign mem_req_valid = !reset && !redirect_valid && (credit_used < (CW + 1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_live      = mem_rsp_valid && !redirect_valid && (discard_q == '0);

`ifdef IFQ_BYPASS_EN
  assign byp = rsp_live && q_empty;
`else
  assign byp = 1'b0;
`endif

  assign q_push  = rsp_live && !(byp && inst_ready);
  assign q_pop   = !q_empty && inst_ready && !redirect_valid;
  assign q_wdata = '{pc: rsp_pc, instr: mem_rsp_data};

  ifetch_queue_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_live),
    .rdata_o (rsp_pc),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  ifetch_queue_sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  logic unused_fifo;
  assign unused_fifo = ^{pend_full, pend_empty, pend_count, q_full};

  always_comb begin
    inst_valid = !q_empty || byp;
    inst_data  = NOP_INSTR;
    inst_pc    = '0;
    if (byp) begin
      inst_data = mem_rsp_data;
      inst_pc   = rsp_pc;
    end else if (!q_empty) begin
      inst_data = q_head.instr;
      inst_pc   = q_head.pc;
    end
    inst_pcplus4 = inst_pc + 32'd4;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(mem_rsp_valid);
    discard_d  = discard_q;
    state_d    = state_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      // A response landing in the redirect cycle is itself stale.
      discard_d  = inflight_q - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
    case (state_q)
      StRun:   if (redirect_valid && (discard_d != '0)) state_d = StDrain;
      StDrain: if (discard_d == '0) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      state_q    <= StRun;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue with an in-order variable-latency memory model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0200;
`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pcplus4   (inst_pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle = 0;
  int unsigned epoch = 0;
  int unsigned last_due = 0;
  int unsigned fires = 0;
  int unsigned lat = 1;
  int unsigned jit = 0;
  int unsigned p_ready = 100;
  int unsigned p_inst_ready = 100;
  int unsigned p_redirect = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;
  logic [31:0] model_pc = RST_PC;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: compare every accepted instruction against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst actual_pc=%h required=none (cycle %0d)", inst_pc, cycle);
      end else begin
        e = exp_q.pop_front();
        check32("inst_pc", inst_pc, e.pc);
        check32("inst_data", inst_data, e.data);
        check32("inst_pcplus4", inst_pcplus4, e.pc + 32'd4);
      end
    end
  end

  // One clock of stimulus: memory response, redirect, handshakes, then request capture.
  task automatic step(input bit rst_now);
    int unsigned sz_before;
    int unsigned due;
    bit          live;
    mreq_t       m;
    @(posedge clk);
    cycle++;
    #1;
    reset          = rst_now;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    live           = 1'b0;
    sz_before      = exp_q.size();
    if (rst_now) begin
      mem_q.delete();
      exp_q.delete();
      model_pc = RST_PC;
      epoch++;
      last_due = 0;
    end else begin
      if (force_redir || ($urandom_range(99) < p_redirect)) begin
        redirect_valid = 1'b1;
        if (force_redir) redirect_pc = force_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else redirect_pc = $urandom;
        force_redir = 1'b0;
        epoch++;
        model_pc = redirect_pc & 32'hFFFF_FFFC;
        exp_q.delete();
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
        m = mem_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = m.data;
        if (m.epoch == epoch) begin
          live = 1'b1;
          exp_q.push_back('{pc: m.pc, data: m.data});
        end
      end
    end
    inst_ready    = ($urandom_range(99) < p_inst_ready);
    mem_req_ready = ($urandom_range(99) < p_ready);
    #3;
    if (rst_now) begin
      check32("req_valid_in_reset", 32'(mem_req_valid), 32'd0);
    end else begin
      if (redirect_valid) check32("req_on_redirect", 32'(mem_req_valid), 32'd0);
      else check32("inst_valid", 32'(inst_valid), 32'((sz_before > 0) || (BYPASS && live)));
      check32("occupancy_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
      if (mem_req_valid && mem_req_ready) begin
        check32("req_addr", mem_req_addr, model_pc);
        due = cycle + lat + $urandom_range(jit);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{pc: model_pc, data: $urandom, due: due, epoch: epoch});
        model_pc = model_pc + 32'd4;
        fires++;
      end
    end
  endtask

  int unsigned ph_lat[4]   = '{1, 2, 3, 2};
  int unsigned ph_jit[4]   = '{0, 2, 0, 3};
  int unsigned ph_ready[4] = '{100, 70, 50, 85};
  int unsigned ph_iready[4] = '{100, 60, 30, 80};
  int unsigned ph_redir[4] = '{3, 5, 4, 6};

  initial begin
    // Reset state
    p_inst_ready = 50;
    repeat (3) step(1'b1);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst_data", inst_data, 32'h0000_0013);
    check32("rst_inst_pc", inst_pc, 32'd0);
    check32("rst_inst_pcplus4", inst_pcplus4, 32'd4);

    // Stall: decode never ready, DEPTH requests then none until a pop
    p_inst_ready = 0;
    p_ready = 100;
    lat = 1;
    fires = 0;
    step(1'b0);
    check32("first_req_valid", 32'(mem_req_valid), 32'd1);
    repeat (9) step(1'b0);
    check32("stall_fires", fires, DEPTH);
    check32("stall_req_valid", 32'(mem_req_valid), 32'd0);
    fires = 0;
    p_inst_ready = 100;
    step(1'b0);
    p_inst_ready = 0;
    repeat (6) step(1'b0);
    check32("refill_fires", fires, 32'd1);

    // Redirect with three fetches in flight
    step(1'b1);
    p_inst_ready = 100;
    lat = 4;
    repeat (3) step(1'b0);
    force_redir = 1'b1;
    force_pc = 32'h0000_0100;
    step(1'b0);
    repeat (15) step(1'b0);

    // Redirect coinciding with a response and a pop
    lat = 1;
    repeat (6) step(1'b0);
    force_redir = 1'b1;
    force_pc = 32'h0000_0403;
    step(1'b0);
    check32("flush_empty", exp_q.size(), 32'd0);
    repeat (8) step(1'b0);

    // Reset while draining stale responses
    lat = 4;
    step(1'b1);
    repeat (3) step(1'b0);
    force_redir = 1'b1;
    force_pc = 32'h0000_0800;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    check32("post_rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    repeat (10) step(1'b0);

    // Randomized phases
    for (int p = 0; p < 4; p++) begin
      lat = ph_lat[p];
      jit = ph_jit[p];
      p_ready = ph_ready[p];
      p_inst_ready = ph_iready[p];
      p_redirect = ph_redir[p];
      repeat (1200) step(1'b0);
    end

    // Drain everything outstanding
    p_redirect = 0;
    p_ready = 0;
    p_inst_ready = 100;
    repeat (40) step(1'b0);
    check32("drain_exp_empty", exp_q.size(), 32'd0);
    check32("drain_mem_empty", mem_q.size(), 32'd0);
    check32("drain_inst_valid", 32'(inst_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
